fpu_result_checker: RTL and testbench

Synthesizable result checker sitting on the output side of the FPU. It absorbs the expected-result stream pushed by whatever issues operands, aligns it in order with the FPU's result stream, and classifies each result. Classes are exact match, rounding error (±1 LSB of the raw 32-bit pattern) or mismatch. Running counters are exposed for on-chip self-test and regression without a simulator file flow.

---
 rtl/fpu_chk_pkg.sv | 16 +
 rtl/fpu_chk_fifo.sv | 66 ++++++
 rtl/fpu_result_checker.sv | 154 +++++++++++++++
 tb/tb_fpu_result_checker.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_chk_pkg.sv
// Shared definitions for the FPU result checker: comparison classes and the
// +/-1 LSB tolerance test on raw 32-bit patterns.
// Latency: n/a (package). Backpressure: n/a.
package fpu_chk_pkg;

  localparam logic [1:0] CLS_MATCH    = 2'd0;
  localparam logic [1:0] CLS_ROUND    = 2'd1;
  localparam logic [1:0] CLS_MISMATCH = 2'd2;
  localparam logic [1:0] CLS_UNDERRUN = 2'd3;

  // diff is res - exp modulo 2^32, so -1 appears as all-ones.
  function automatic logic is_one_lsb(input logic [31:0] diff);
    return (diff == 32'h0000_0001) || (diff == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/fpu_chk_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits, head visible combinationally.
// Latency: a push is readable after the next clock edge (no bypass).
// Backpressure: pushes while full and pops while empty are dropped; clr wins over both.
// Ports: clk_i/rst_i (async, active-high), clr_i sync flush, wr_en_i/wr_data_i push,
//        rd_en_i pop, rd_data_o head entry, full_o/empty_o status.
module fpu_chk_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push, pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push = wr_en_i && !full_o  && !clr_i;
  assign pop  = rd_en_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fpu_result_checker.sv
// Aligns expected results with the FPU result stream and classifies each pair
// (match / +-1 LSB / mismatch / underrun), keeping saturating counters.
// Latency: res_valid sampled at edge N -> cmp_* and stats updated at edge N+1.
// Backpressure: exp_ready = !full; results cannot be stalled.
// Ports: CLK/RST (async, active-high), clr sync flush, exp_* expected stream,
//        res_* FPU results, cmp_* per-result pulse, num_* counters, underrun,
//        last_bad_* capture of the most recent mismatch.
module fpu_result_checker
  import fpu_chk_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             exp_valid,
  input  logic [31:0]      exp_data,
  output logic             exp_ready,
  input  logic             res_valid,
  input  logic [31:0]      res_data,
  output logic             cmp_valid,
  output logic [1:0]       cmp_class,
  output logic [CNT_W-1:0] num_match,
  output logic [CNT_W-1:0] num_round,
  output logic [CNT_W-1:0] num_mismatch,
  output logic             underrun,
  output logic [31:0]      last_bad_res,
  output logic [31:0]      last_bad_exp
);

  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;

  fpu_chk_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (clr),
    .wr_en_i   (exp_valid),
    .wr_data_i (exp_data),
    .rd_en_i   (res_valid),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign exp_ready = !fifo_full;

  // Stage 1 captures the popped pair so the subtract/classify sits off the
  // FIFO read path; stage 2 holds the architectural outputs.
  logic             s1_vld_q, s1_vld_d;
  logic             s1_under_q, s1_under_d;
  logic [31:0]      s1_res_q, s1_res_d;
  logic [31:0]      s1_exp_q, s1_exp_d;

  logic             cmp_valid_q, cmp_valid_d;
  logic [1:0]       cmp_class_q, cmp_class_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic             underrun_q, underrun_d;
  logic [31:0]      bad_res_q, bad_res_d;
  logic [31:0]      bad_exp_q, bad_exp_d;

  logic [31:0]      diff;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign diff = s1_res_q - s1_exp_q;

  always_comb begin
    s1_vld_d    = res_valid;
    s1_under_d  = fifo_empty;
    s1_res_d    = res_data;
    s1_exp_d    = fifo_head;
    cmp_valid_d = s1_vld_q;
    cmp_class_d = cmp_class_q;
    match_d     = match_q;
    round_d     = round_q;
    mism_d      = mism_q;
    underrun_d  = underrun_q;
    bad_res_d   = bad_res_q;
    bad_exp_d   = bad_exp_q;

    if (s1_vld_q) begin
      if (s1_under_q) begin
        cmp_class_d = CLS_UNDERRUN;
        underrun_d  = 1'b1;
      end else if (diff == 32'd0) begin
        cmp_class_d = CLS_MATCH;
        if (match_q != CNT_MAX) match_d = match_q + CNT_W'(1);
      end else if (is_one_lsb(diff)) begin
        cmp_class_d = CLS_ROUND;
        if (round_q != CNT_MAX) round_d = round_q + CNT_W'(1);
      end else begin
        cmp_class_d = CLS_MISMATCH;
        if (mism_q != CNT_MAX) mism_d = mism_q + CNT_W'(1);
        bad_res_d = s1_res_q;
        bad_exp_d = s1_exp_q;
      end
    end

    // A flush also kills any comparison still in flight.
    if (clr) begin
      s1_vld_d    = 1'b0;
      cmp_valid_d = 1'b0;
      match_d     = '0;
      round_d     = '0;
      mism_d      = '0;
      underrun_d  = 1'b0;
      bad_res_d   = '0;
      bad_exp_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld_q    <= 1'b0;
      s1_under_q  <= 1'b0;
      s1_res_q    <= '0;
      s1_exp_q    <= '0;
      cmp_valid_q <= 1'b0;
      cmp_class_q <= 2'b00;
      match_q     <= '0;
      round_q     <= '0;
      mism_q      <= '0;
      underrun_q  <= 1'b0;
      bad_res_q   <= '0;
      bad_exp_q   <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_under_q  <= s1_under_d;
      s1_res_q    <= s1_res_d;
      s1_exp_q    <= s1_exp_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_class_q <= cmp_class_d;
      match_q     <= match_d;
      round_q     <= round_d;
      mism_q      <= mism_d;
      underrun_q  <= underrun_d;
      bad_res_q   <= bad_res_d;
      bad_exp_q   <= bad_exp_d;
    end
  end

  assign cmp_valid    = cmp_valid_q;
  assign cmp_class    = cmp_class_q;
  assign num_match    = match_q;
  assign num_round    = round_q;
  assign num_mismatch = mism_q;
  assign underrun     = underrun_q;
  assign last_bad_res = bad_res_q;
  assign last_bad_exp = bad_exp_q;

endmodule

// File: tb/tb_fpu_result_checker.sv
// Scoreboard bench for fpu_result_checker: directed test-plan cases plus random
// traffic against a queue-based reference model; a 4-bit-counter twin checks saturation.
// Latency checked: result at edge E must be reported after edge E+1.
module tb_fpu_result_checker;
  import fpu_chk_pkg::*;

  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic clr = 1'b0;
  logic exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic res_valid = 1'b0;
  logic [31:0] res_data = '0;

  logic exp_ready, cmp_valid, underrun;
  logic [1:0] cmp_class;
  logic [15:0] num_match, num_round, num_mismatch;
  logic [31:0] last_bad_res, last_bad_exp;

  logic exp_ready4, cmp_valid4, underrun4;
  logic [1:0] cmp_class4;
  logic [3:0] num_match4, num_round4, num_mismatch4;
  logic [31:0] last_bad_res4, last_bad_exp4;

  fpu_result_checker #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .clr(clr),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .res_valid(res_valid), .res_data(res_data),
    .cmp_valid(cmp_valid), .cmp_class(cmp_class),
    .num_match(num_match), .num_round(num_round), .num_mismatch(num_mismatch),
    .underrun(underrun), .last_bad_res(last_bad_res), .last_bad_exp(last_bad_exp)
  );

  fpu_result_checker #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .clr(clr),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready4),
    .res_valid(res_valid), .res_data(res_data),
    .cmp_valid(cmp_valid4), .cmp_class(cmp_class4),
    .num_match(num_match4), .num_round(num_round4), .num_mismatch(num_mismatch4),
    .underrun(underrun4), .last_bad_res(last_bad_res4), .last_bad_exp(last_bad_exp4)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [1:0]  cls;
    int unsigned m, r, x;
    logic [31:0] lbr, lbe;
    logic        und;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq[$];
  int unsigned cm = 0, cr = 0, cx = 0;
  logic [31:0] mlbr = '0, mlbe = '0;
  logic        mund = 1'b0;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    cm = 0; cr = 0; cx = 0;
    mlbr = '0; mlbe = '0; mund = 1'b0;
  endtask

  // Applies one clock's worth of stimulus to the model; e is the index of
  // the edge just taken minus one.
  task automatic model_step(input int e, input bit p, input logic [31:0] pd,
                            input bit r, input logic [31:0] rd, input bit c);
    int sz;
    exp_t x;
    logic [31:0] hd, d;
    if (c) begin
      mq.delete();
      cm = 0; cr = 0; cx = 0;
      mlbr = '0; mlbe = '0; mund = 1'b0;
      // a result captured at the previous edge never gets reported
      while (sb.size() > 0 && sb[sb.size()-1].due == e + 1) void'(sb.pop_back());
      return;
    end
    sz = mq.size();
    if (r) begin
      if (sz == 0) begin
        mund = 1'b1;
        x.cls = CLS_UNDERRUN;
      end else begin
        hd = mq.pop_front();
        d  = rd - hd;
        if (d == 32'd0) begin
          x.cls = CLS_MATCH; cm++;
        end else if (d == 32'd1 || d == 32'hFFFF_FFFF) begin
          x.cls = CLS_ROUND; cr++;
        end else begin
          x.cls = CLS_MISMATCH; cx++;
          mlbr = rd; mlbe = hd;
        end
      end
      x.due = e + 2;
      x.m = cm; x.r = cr; x.x = cx;
      x.lbr = mlbr; x.lbe = mlbe; x.und = mund;
      sb.push_back(x);
    end
    if (p && sz < DEPTH) mq.push_back(pd);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit p, input logic [31:0] pd, input bit r,
                      input logic [31:0] rd, input bit c);
    int e;
    @(negedge CLK);
    exp_valid = p; exp_data = pd;
    res_valid = r; res_data = rd;
    clr = c;
    #1;
    chk("exp_ready", exp_ready, mq.size() < DEPTH);
    chk("exp_ready4", exp_ready4, mq.size() < DEPTH);
    @(posedge CLK);
    e = edge_cnt;
    model_step(e, p, pd, r, rd, c);
    #1;
    exp_valid = 1'b0; res_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic push(input logic [31:0] v); step(1, v, 0, '0, 0); endtask
  task automatic res(input logic [31:0] v);  step(0, '0, 1, v, 0); endtask
  task automatic idle();                     step(0, '0, 0, '0, 0); endtask

  task automatic rst_pulse();
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_cmp_class", cmp_class, 0);
    chk("rst_num_match", num_match, 0);
    chk("rst_num_round", num_round, 0);
    chk("rst_num_mismatch", num_mismatch, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_last_bad_res", last_bad_res, 0);
    chk("rst_last_bad_exp", last_bad_exp, 0);
    chk("rst_exp_ready", exp_ready, 1);
    chk("rst_num_match4", num_match4, 0);
    #1 RST = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge CLK);
      if (RST) continue;
      if (sb.size() > 0 && sb[0].due == edge_cnt) begin
        x = sb.pop_front();
        chk("cmp_valid", cmp_valid, 1);
        chk("cmp_valid4", cmp_valid4, 1);
        chk("cmp_class", cmp_class, x.cls);
        chk("cmp_class4", cmp_class4, x.cls);
        chk("num_match", num_match, sat(x.m, 65535));
        chk("num_round", num_round, sat(x.r, 65535));
        chk("num_mismatch", num_mismatch, sat(x.x, 65535));
        chk("num_match4", num_match4, sat(x.m, 15));
        chk("num_round4", num_round4, sat(x.r, 15));
        chk("num_mismatch4", num_mismatch4, sat(x.x, 15));
        chk("underrun", underrun, x.und);
        chk("last_bad_res", last_bad_res, x.lbr);
        chk("last_bad_exp", last_bad_exp, x.lbe);
      end else begin
        chk("cmp_valid_idle", cmp_valid, 0);
        chk("cmp_valid4_idle", cmp_valid4, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] hd, rd;
    bit p, r, c;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("init_cmp_valid", cmp_valid, 0);
    chk("init_cmp_class", cmp_class, 0);
    chk("init_counters", {num_match, num_round, num_mismatch}, 0);
    chk("init_underrun", underrun, 0);
    chk("init_last_bad", {last_bad_res, last_bad_exp}, 0);
    chk("init_exp_ready", exp_ready, 1);

    // exact match
    push(32'h3F80_0000); res(32'h3F80_0000); idle();
    chk("tp_match_cnt", num_match, 1);

    // +1, -1 and wrap-around rounding
    push(32'h4049_0FDB); res(32'h4049_0FDC);
    push(32'h4049_0FDB); res(32'h4049_0FDA);
    push(32'h0000_0000); res(32'hFFFF_FFFF); idle();
    chk("tp_round_cnt", num_round, 3);

    // sign flip is a mismatch
    push(32'h4120_0000); res(32'hC120_0000); idle();
    chk("tp_bad_res", last_bad_res, 32'hC120_0000);
    chk("tp_bad_exp", last_bad_exp, 32'h4120_0000);

    // fill, ignored 9th push, push+pop while full, refill, ordered drain
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + i);
    push(32'hDEAD_0009);
    step(1, 32'hBEEF_0000, 1, 32'h1000, 0);
    push(32'h2000_0000);
    while (mq.size() > 0) begin
      hd = mq[0];
      res(hd);
    end
    idle();

    // underrun with same-cycle push; pushed value survives
    step(1, 32'h5555_0000, 1, 32'h7777_0000, 0);
    res(32'h5555_0000); idle();
    chk("tp_underrun", underrun, 1);

    // clr with queued entries and a result in flight
    push(32'hA); push(32'hB); res(32'hA);
    step(1, 32'hC, 1, 32'hB, 1);
    res(32'h1234); idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      p = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 199) == 0);
      if (mq.size() > 0) begin
        hd = mq[0];
        case ($urandom_range(0, 3))
          0: rd = hd;
          1: rd = hd + 32'd1;
          2: rd = hd - 32'd1;
          default: rd = $urandom;
        endcase
      end else rd = $urandom;
      step(p, $urandom, r, rd, c);
    end
    repeat (3) idle();

    // 20 matches, then async reset mid-cycle
    for (int i = 0; i < 20; i++) begin push(32'h100 + i); res(32'h100 + i); end
    rst_pulse();
    idle();
    chk("post_rst_empty_ready", exp_ready, 1);

    // 17 matches: 16-bit counter reads 17, 4-bit counter pins at 15
    for (int i = 0; i < 17; i++) step(1, 32'h900 + i, i > 0, 32'h900 + i - 1, 0);
    res(32'h910); idle(); idle();
    chk("sat_cnt16", num_match, 17);
    chk("sat_cnt4", num_match4, 15);

    repeat (3) idle();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
